// File: rtl/spi_load_master.sv
// SPI write master: shifts {CMD_WRITE, addr, data} MSB first to an SPI slave, one word per
// request, with programmable SCK half-period and chip-select gap.
module spi_load_master #(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [7:0]  CMD_WRITE = 8'h02,
    parameter int unsigned CS_GAP    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    output logic        spi_sck_o,
    output logic        spi_csn_o,
    output logic        spi_sdo0_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StShift,
        StCsHold,
        StGap
    } state_e;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    // The IDLE cycle is the last CSN-high cycle, so GAP itself lasts CS_GAP-1 cycles.
    localparam logic [7:0] GAP_LOAD = (CS_GAP > 1) ? 8'(CS_GAP - 2) : 8'd0;
    localparam logic [6:0] LAST_BIT = 7'd71;

    state_e      state_q;
    logic [7:0]  div_q;
    logic [6:0]  bit_cnt_q;
    logic [71:0] shreg_q;
    logic        sck_q;
    logic        csn_q;
    logic        done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            sck_q     <= 1'b0;
            csn_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        shreg_q   <= {CMD_WRITE, req_addr_i, req_data_i};
                        csn_q     <= 1'b0;
                        div_q     <= DIV_LOAD;
                        bit_cnt_q <= '0;
                        state_q   <= StCsSetup;
                    end
                end
                StCsSetup: begin
                    if (div_q == 8'd0) begin
                        sck_q   <= 1'b1;
                        div_q   <= DIV_LOAD;
                        state_q <= StShift;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                StShift: begin
                    if (div_q != 8'd0) begin
                        div_q <= div_q - 8'd1;
                    end else begin
                        div_q <= DIV_LOAD;
                        if (sck_q) begin
                            // Data advances only on the falling edge; the last bit stays put.
                            sck_q <= 1'b0;
                            if (bit_cnt_q != LAST_BIT) begin
                                shreg_q <= {shreg_q[70:0], 1'b0};
                            end
                        end else if (bit_cnt_q == LAST_BIT) begin
                            state_q <= StCsHold;
                        end else begin
                            sck_q     <= 1'b1;
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                        end
                    end
                end
                StCsHold: begin
                    if (div_q == 8'd0) begin
                        csn_q     <= 1'b1;
                        done_q    <= 1'b1;
                        shreg_q   <= '0;
                        bit_cnt_q <= '0;
                        div_q     <= GAP_LOAD;
                        state_q   <= StGap;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                StGap: begin
                    if (div_q == 8'd0) begin
                        state_q <= StIdle;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign spi_sck_o   = sck_q;
    assign spi_csn_o   = csn_q;
    assign spi_sdo0_o  = shreg_q[71];

endmodule
